// File: rtl/zx8x_tape_pkg.sv
// Shared definitions for the tape fast-load path: copy-engine states,
// ROM LOAD trap addresses, destination offsets and patch return bytes.
// The top level's patch ROM mux imports this package as well.
package zx8x_tape_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COPY  = 2'd2,
        ST_DONE  = 2'd3
    } tape_state_e;

    // LOAD entry point (patch base) and first address past the trap window
    localparam logic [15:0] ZX81_TRAP_LO = 16'h0347;
    localparam logic [15:0] ZX81_TRAP_HI = 16'h03C3;
    localparam logic [15:0] ZX80_TRAP_LO = 16'h0207;
    localparam logic [15:0] ZX80_TRAP_HI = 16'h024D;

    // .p images start at $4009 (system variables after the first 9 bytes),
    // .o images at $4000
    localparam logic [13:0] DST_OFS_P = 14'd9;
    localparam logic [13:0] DST_OFS_O = 14'd0;

    // Low byte of the jump the patch uses to leave the wait loop
    localparam logic [7:0] RET_LO_ZX81 = 8'h07;
    localparam logic [7:0] RET_LO_ZX80 = 8'h03;

    function automatic logic [7:0] patch_ret_byte(input logic zx81);
        return zx81 ? RET_LO_ZX81 : RET_LO_ZX80;
    endfunction

endpackage

// File: rtl/tape_dma_ctrl_if.sv
// Memory-side bus of the tape copy engine: CPU write request into the
// arbiter, arbitrated system RAM write port, and the tape buffer read port.
// master = the copy engine, slave = the CPU/RAM/buffer surroundings.
interface tape_dma_ctrl_if;

    logic        cpu_ram_we;
    logic [13:0] cpu_ram_addr;
    logic [7:0]  cpu_ram_din;

    logic        ram_we;
    logic [13:0] ram_addr;
    logic [7:0]  ram_din;

    logic [13:0] buf_addr;
    logic [7:0]  buf_data;

    modport master (
        input  cpu_ram_we, cpu_ram_addr, cpu_ram_din, buf_data,
        output ram_we, ram_addr, ram_din, buf_addr
    );

    modport slave (
        output cpu_ram_we, cpu_ram_addr, cpu_ram_din, buf_data,
        input  ram_we, ram_addr, ram_din, buf_addr
    );

endinterface

// File: rtl/tape_trap_det.sv
// M1 falling-edge detector with LOAD trap compare. trap_hit flags an opcode
// fetch of the model's LOAD entry; window_exit flags an opcode fetch outside
// the patched ROM window. Both are combinational in the fetch cycle.
module tape_trap_det
    import zx8x_tape_pkg::*;
#(
    parameter logic [15:0] TRAP81_LO = ZX81_TRAP_LO,
    parameter logic [15:0] TRAP81_HI = ZX81_TRAP_HI,
    parameter logic [15:0] TRAP80_LO = ZX80_TRAP_LO,
    parameter logic [15:0] TRAP80_HI = ZX80_TRAP_HI
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        zx81,
    input  logic        cpu_m1_n,
    input  logic [15:0] cpu_addr,
    output logic        trap_hit,
    output logic        window_exit
);

    logic        m1_prev_q;
    logic        m1_prev_d;
    logic        m1_fall;
    logic [15:0] win_lo;
    logic [15:0] win_hi;

    // Previous M1 sample; cleared on reset so no edge is seen right after it
    always_comb begin
        m1_prev_d = cpu_m1_n;
    end

    // Register the previous M1 level
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            m1_prev_q <= 1'b0;
        end else begin
            m1_prev_q <= m1_prev_d;
        end
    end

    assign win_lo      = zx81 ? TRAP81_LO : TRAP80_LO;
    assign win_hi      = zx81 ? TRAP81_HI : TRAP80_HI;
    assign m1_fall     = m1_prev_q & ~cpu_m1_n;
    assign trap_hit    = m1_fall & (cpu_addr == win_lo);
    assign window_exit = m1_fall & ((cpu_addr < win_lo) | (cpu_addr >= win_hi));

endmodule

// File: rtl/tape_dma_ctrl.sv
// Tape fast-load sequencer. When the CPU fetches the LOAD entry point, the
// downloaded image is copied from the tape buffer into system RAM while the
// ROM patch keeps the CPU spinning; the patch is switched to its exit opcode
// once the last byte is written. The CPU always wins the shared RAM port.
module tape_dma_ctrl
    import zx8x_tape_pkg::*;
#(
    parameter logic [15:0] TRAP81_LO = ZX81_TRAP_LO,
    parameter logic [15:0] TRAP81_HI = ZX81_TRAP_HI,
    parameter logic [15:0] TRAP80_LO = ZX80_TRAP_LO,
    parameter logic [15:0] TRAP80_HI = ZX80_TRAP_HI,
    parameter logic [13:0] OFS_P     = DST_OFS_P,
    parameter logic [13:0] OFS_O     = DST_OFS_O
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               zx81,
    input  logic               tape_arm,
    input  logic               fmt_p,
    input  logic [13:0]        tape_last,
    input  logic               cpu_m1_n,
    input  logic [15:0]        cpu_addr,
    tape_dma_ctrl_if.master    bus,
    output logic               patch_active,
    output logic               patch_scf,
    output logic [7:0]         patch_ret_lo,
    output logic               tape_ready,
    output logic               busy
);

    tape_state_e state_q, state_d;
    logic [13:0] src_q, src_d;
    logic [13:0] last_q, last_d;
    logic        fmt_p_q, fmt_p_d;
    logic        patch_active_q, patch_active_d;
    logic        patch_scf_q, patch_scf_d;
    logic        dma_we_q, dma_we_d;

    logic        trap_hit;
    logic        window_exit;
    logic        dma_fire;
    logic [13:0] dma_addr;

    tape_trap_det #(
        .TRAP81_LO (TRAP81_LO),
        .TRAP81_HI (TRAP81_HI),
        .TRAP80_LO (TRAP80_LO),
        .TRAP80_HI (TRAP80_HI)
    ) u_trap_det (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .zx81        (zx81),
        .cpu_m1_n    (cpu_m1_n),
        .cpu_addr    (cpu_addr),
        .trap_hit    (trap_hit),
        .window_exit (window_exit)
    );

    // A pending DMA write only completes when the CPU is not using the port
    assign dma_fire = dma_we_q & ~bus.cpu_ram_we;
    // Destination wraps naturally in 14 bits
    assign dma_addr = src_q + (fmt_p_q ? OFS_P : OFS_O);

    // Next state: arming, trap entry, copy progress, window exit
    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        last_d         = last_q;
        fmt_p_d        = fmt_p_q;
        patch_active_d = patch_active_q;
        patch_scf_d    = patch_scf_q;
        dma_we_d       = dma_we_q;

        if (tape_arm) begin
            // A new image always wins, including over a same-cycle trap
            fmt_p_d  = fmt_p;
            last_d   = tape_last;
            src_d    = '0;
            dma_we_d = 1'b0;
            state_d  = ST_ARMED;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dma_we_d = 1'b0;
                end
                ST_ARMED, ST_DONE: begin
                    dma_we_d = 1'b0;
                    if (trap_hit) begin
                        src_d          = '0;
                        patch_active_d = 1'b1;
                        patch_scf_d    = 1'b0;
                        state_d        = ST_COPY;
                    end
                end
                ST_COPY: begin
                    // Read of src was issued last cycle; keep a write pending
                    dma_we_d = 1'b1;
                    if (dma_fire) begin
                        src_d = src_q + 14'd1;
                        if (src_q == last_q) begin
                            dma_we_d    = 1'b0;
                            patch_scf_d = 1'b1;
                            state_d     = ST_DONE;
                        end
                    end
                    if (window_exit) begin
                        dma_we_d = 1'b0;
                        state_d  = ST_ARMED;
                    end
                end
                default: begin
                    dma_we_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            endcase
        end

        if (window_exit) begin
            patch_active_d = 1'b0;
        end
    end

    // Control and copy-pointer registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            src_q          <= '0;
            last_q         <= '0;
            fmt_p_q        <= 1'b0;
            patch_active_q <= 1'b0;
            patch_scf_q    <= 1'b0;
            dma_we_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            last_q         <= last_d;
            fmt_p_q        <= fmt_p_d;
            patch_active_q <= patch_active_d;
            patch_scf_q    <= patch_scf_d;
            dma_we_q       <= dma_we_d;
        end
    end

    // Read one ahead when the current write lands so writes can go
    // back-to-back; on a stall the same byte is re-read and stays on buf_data.
    assign bus.buf_addr = dma_fire ? (src_q + 14'd1) : src_q;

    assign bus.ram_we   = bus.cpu_ram_we | dma_we_q;
    assign bus.ram_addr = bus.cpu_ram_we ? bus.cpu_ram_addr : dma_addr;
    assign bus.ram_din  = bus.cpu_ram_we ? bus.cpu_ram_din  : bus.buf_data;

    assign patch_active = patch_active_q;
    assign patch_scf    = patch_scf_q;
    assign patch_ret_lo = patch_ret_byte(zx81);
    assign tape_ready   = (state_q != ST_IDLE);
    assign busy         = (state_q == ST_COPY);

endmodule
